// File: rtl/match_reporter_pkg.sv
// rtl/match_reporter_pkg.sv - serializer states, default header byte and packet lengths
// MATCH_REPORTER_CSUM_EN adds the checksum state and a fifth packet byte.
package match_reporter_pkg;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int         ENTRY_W          = 24;
  localparam int         PKT_LEN_BASE     = 4;
  localparam int         PKT_LEN_CSUM     = 5;

`ifdef MATCH_REPORTER_CSUM_EN
  localparam int PKT_LEN = PKT_LEN_CSUM;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_B1, S_B2, S_B3, S_CSUM} ser_state_t;
`else
  localparam int PKT_LEN = PKT_LEN_BASE;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_B1, S_B2, S_B3} ser_state_t;
`endif

endpackage

// File: rtl/match_fifo.sv
// rtl/match_fifo.sv - match entry queue with same-edge push/pop and occupancy count
module match_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [5:0]       count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage is never reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == 6'(DEPTH));
  assign empty = (count == 6'd0);

endmodule

// File: rtl/match_reporter.sv
// rtl/match_reporter.sv - queues new match positions and serializes them as byte packets
// MATCH_REPORTER_CSUM_EN appends an XOR checksum of the three payload bytes.
module match_reporter
  import match_reporter_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       ovf_clr,
  output logic       overflow,
  output logic [5:0] fifo_count
);

  ser_state_t         state_q, state_d;
  logic [19:0]        last_pos;
  logic [3:0]         seq;
  logic [ENTRY_W-1:0] pkt;
  logic [ENTRY_W-1:0] head;
  logic               full, empty, pop, push, drop, new_match;

  assign new_match = ({xpos, ypos} != last_pos);
  // A full FIFO still accepts when the serializer frees a slot on the same edge.
  assign push = new_match && (!full || pop);
  assign drop = new_match && full && !pop;

  match_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({xpos, ypos, seq}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_pos <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      pkt      <= '0;
    end else begin
      state_q <= state_d;
      if (new_match) last_pos <= {xpos, ypos};
      if (push)      seq <= seq + 4'd1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (pop)       pkt <= head;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) state_d = S_B1;
      end
      S_B1: begin
        tx_valid = 1'b1;
        tx_data  = pkt[23:16];
        if (tx_ready) state_d = S_B2;
      end
      S_B2: begin
        tx_valid = 1'b1;
        tx_data  = pkt[15:8];
        if (tx_ready) state_d = S_B3;
      end
`ifdef MATCH_REPORTER_CSUM_EN
      S_B3: begin
        tx_valid = 1'b1;
        tx_data  = pkt[7:0];
        if (tx_ready) state_d = S_CSUM;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = pkt[23:16] ^ pkt[15:8] ^ pkt[7:0];
        if (tx_ready) begin
          pop     = !empty;
          state_d = empty ? S_IDLE : S_HDR;
        end
      end
`else
      S_B3: begin
        tx_valid = 1'b1;
        tx_data  = pkt[7:0];
        if (tx_ready) begin
          pop     = !empty;
          state_d = empty ? S_IDLE : S_HDR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_match_reporter.sv
// tb/tb_match_reporter.sv - directed and random checks of match_reporter against a queue model
module tb_match_reporter;
  import match_reporter_pkg::*;

  localparam int DEPTH = 8;
  localparam int PLEN  = PKT_LEN;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] xpos, ypos;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, ovf_clr, overflow;
  logic [5:0] fifo_count;

  int checks = 0;
  int failures = 0;

  // Reference model: queued entries, packet in flight as a byte list.
  logic [23:0] mq[$];
  logic [19:0] m_last;
  logic [3:0]  m_seq;
  logic        m_ovf;
  int          m_rem;
  logic [7:0]  m_bytes[5];
  logic [7:0]  got_bytes[$];
  logic        stall;
  logic [7:0]  sdata;

  match_reporter #(.FIFO_DEPTH(DEPTH), .HDR_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_seq  = '0;
    m_ovf  = 1'b0;
    m_rem  = 0;
  endtask

  task automatic model_edge();
    logic [23:0] e;
    bit do_pop, newm, full, drop;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_rem > 0 && tx_ready) m_rem--;
    do_pop = (m_rem == 0) && (mq.size() > 0);
    full   = (mq.size() == DEPTH);
    newm   = ({xpos, ypos} != m_last);
    drop   = newm && full && !do_pop;
    if (drop)         m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (do_pop) begin
      e = mq.pop_front();
      m_bytes[0] = 8'hA5;
      m_bytes[1] = e[23:16];
      m_bytes[2] = e[15:8];
      m_bytes[3] = e[7:0];
      m_bytes[4] = e[23:16] ^ e[15:8] ^ e[7:0];
      m_rem = PLEN;
    end
    if (newm && !drop) begin
      mq.push_back({xpos, ypos, m_seq});
      m_seq = m_seq + 4'd1;
    end
    if (newm) m_last = {xpos, ypos};
  endtask

  // One clock: inputs are already settled; outputs checked on the falling edge.
  task automatic cycle();
    bit   cap;
    logic [7:0] cdata;
    cap   = tx_valid && tx_ready && !rst;
    cdata = tx_data;
    stall = tx_valid && !tx_ready && !rst;
    sdata = tx_data;
    @(posedge clk);
    model_edge();
    if (cap) got_bytes.push_back(cdata);
    @(negedge clk);
    if (stall && !rst) begin
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'(sdata));
    end
    chk("tx_valid", 32'(tx_valid), 32'(m_rem > 0));
    if (m_rem > 0) chk("tx_data", 32'(tx_data), 32'(m_bytes[PLEN - m_rem]));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    rst = 1'b1; xpos = '0; ypos = '0; tx_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    cycle(); cycle();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    cycle();

    // Single packet for (40,100), then held position yields nothing more.
    got_bytes.delete();
    xpos = 10'd40; ypos = 10'd100; tx_ready = 1'b1;
    for (int i = 0; i < 50; i++) cycle();
    chk("one_packet_len", 32'(got_bytes.size()), 32'(PLEN));
    chk("pkt_b0", 32'(got_bytes[0]), 32'hA5);
    chk("pkt_b1", 32'(got_bytes[1]), 32'h0A);
    chk("pkt_b2", 32'(got_bytes[2]), 32'h06);
    chk("pkt_b3", 32'(got_bytes[3]), 32'h40);
    if (PLEN == 5) chk("pkt_csum", 32'(got_bytes[4]), 32'h4C);

    // Stall: one packet held by the serializer, then 9 more fill and overflow.
    got_bytes.delete();
    tx_ready = 1'b0;
    xpos = 10'd1; ypos = 10'd1;
    cycle(); cycle();
    for (int i = 0; i < 9; i++) begin
      xpos = 10'(100 + i); ypos = 10'd200;
      cycle();
    end
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain with tx_ready toggling every cycle.
    for (int i = 0; i < 100; i++) begin
      tx_ready = ~tx_ready;
      cycle();
    end
    chk("drain_bytes", 32'(got_bytes.size()), 32'(9 * PLEN));
    chk("drain_count", 32'(fifo_count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        xpos = 10'($urandom_range(0, 3));
        ypos = ($urandom_range(0, 1) == 0) ? 10'd7 : 10'($urandom_range(0, 1023));
      end
      cycle();
    end
    ovf_clr = 1'b0;

    // Sequence wrap over 17 accepted matches.
    rst = 1'b1; xpos = '0; ypos = '0; model_reset();
    cycle(); cycle();
    rst = 1'b0; tx_ready = 1'b1;
    got_bytes.delete();
    for (int i = 1; i <= 17; i++) begin
      xpos = 10'(i); ypos = 10'd3;
      for (int k = 0; k < 6; k++) cycle();
    end
    for (int k = 0; k < 8; k++) cycle();
    chk("wrap_bytes", 32'(got_bytes.size()), 32'(17 * PLEN));
    chk("seq_first", 32'(got_bytes[3][3:0]), 32'd0);
    chk("seq_second", 32'(got_bytes[PLEN + 3][3:0]), 32'd1);
    chk("seq_wrap", 32'(got_bytes[16 * PLEN + 3][3:0]), 32'd0);

    // Reset in the middle of a packet.
    xpos = 10'd5; ypos = 10'd5; cycle();
    xpos = 10'd6; cycle();
    xpos = 10'd7; cycle();
    for (int i = 0; i < 20 && m_rem != PLEN - 2; i++) cycle();
    chk("reach_b2", 32'(m_rem), 32'(PLEN - 2));
    chk("b2_count", 32'(fifo_count != 0), 32'd1);
    rst = 1'b1; model_reset();
    #1;
    chk("midrst_valid", 32'(tx_valid), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_data", 32'(tx_data), 32'h00);
    @(negedge clk);
    cycle();
    xpos = 10'd9; ypos = 10'd9;
    rst = 1'b0;
    got_bytes.delete();
    for (int k = 0; k < 10; k++) cycle();
    chk("post_rst_len", 32'(got_bytes.size()), 32'(PLEN));
    chk("post_rst_hdr", 32'(got_bytes[0]), 32'hA5);
    chk("post_rst_seq", 32'(got_bytes[3][3:0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
